display_feed: RTL
=================

Name: display_feed

Overview:
- Upstream stage of the four-digit 7-segment scanner.
- Derives the 1 kHz scan clock from the system clock.
- Accepts a 16-bit value from the pipeline (PC, register or debug word) with a load strobe and produces four registered 4-bit digits for the scanner.
- Hex mode passes nibbles through; decimal mode runs a sequential shift-add-3 (double-dabble) binary-to-BCD conversion, with saturation above 9999.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency.
- SCAN_FREQ_HZ, 1000, frequency of clk_1K output.
- DIV (local), CLK_FREQ_HZ/(2*SCAN_FREQ_HZ), half-period count of clk_1K. Must be >= 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- value  in  16  binary value to display
- load  in  1  single-cycle strobe; sampled with value and mode
- mode  in  1  0 = hex, 1 = decimal
- busy  out  1  decimal conversion in progress; loads ignored while high
- overflow  out  1  last accepted decimal load exceeded 9999
- clk_1K  out  1  divided scan clock, 50% duty
- count_1  out  4  leftmost (most significant) digit
- count_2  out  4  second digit
- count_3  out  4  third digit
- count_4  out  4  rightmost (least significant) digit

Behaviour:
- Reset (synchronous; wins over load at the same edge):
  - divider counter = 0, clk_1K = 0, all count_n = 0, busy = 0, overflow = 0, state = IDLE.
  - Reset mid-conversion aborts the conversion; digits are the reset values, not partial results.
- Divider:
  - Counter runs 0..DIV-1 every cycle, independent of the FSM.
  - At the edge where counter == DIV-1: counter wraps to 0 and clk_1K toggles. Period = 2*DIV clk cycles.
- Load acceptance: a load is accepted only when state == IDLE. A load while busy is dropped silently, with no queueing and no effect on digits or overflow.
- Hex load (mode=0):
  - At the accepting edge: count_1..4 = value[15:12], [11:8], [7:4], [3:0]; overflow = 0.
  - busy stays 0; latency is 1 edge.
- Decimal load (mode=1), value > 9999:
  - At the accepting edge: all count_n = 9, overflow = 1.
  - busy stays 0; no conversion.
- Decimal load (mode=1), value <= 9999:
  - At the accepting edge: state -> CONV; busy = 1; shift register = value; 16-bit BCD accumulator = 0; iteration counter = 0; overflow = 0.
  - count_n keep their old values until commit.
- CONV state, each cycle:
  - In every BCD nibble of the accumulator that is >= 5, add 3.
  - Then shift {bcd, shift} left by 1 as a 32-bit quantity.
  - Increment the iteration counter.
  - After the 16th iteration, go to DONE.
- DONE state, one cycle: commit accumulator nibbles [15:12], [11:8], [7:4], [3:0] to count_1..4; busy = 0; state -> IDLE.
- Decimal timing:
  - Digits update atomically, exactly 17 edges after the accepting edge.
  - busy is high for exactly 17 cycles.
  - A new load is accepted on the edge at which busy is first observed low.
- Leading zeros are displayed; there is no blanking.
- The clk_1K phase is unaffected by loads and conversions.

Test Plan:
- Reset: assert reset 2 cycles with load=1 held -> all count_n = 0, busy = 0, overflow = 0, clk_1K = 0; divider resumes from 0.
- Divider: CLK_FREQ_HZ=8, SCAN_FREQ_HZ=1 (DIV=4), run 32 cycles -> clk_1K toggles every 4 cycles, period 8, first rise 4 edges after reset release.
- Hex load: value=16'hA3F0, mode=0, one-cycle load -> next cycle count_1..4 = A,3,F,0; busy never rises; overflow = 0.
- Decimal conversion: value=16'd4096, mode=1 -> busy high 17 cycles; digits hold old values throughout, then become 4,0,9,6 together. Also check 0 -> 0,0,0,0 and 9999 -> 9,9,9,9.
- Decimal overflow then clear:
  - value=16'd10000, mode=1 -> next cycle 9,9,9,9, overflow = 1, busy = 0.
  - Then hex load 16'h0012 -> 0,0,1,2, overflow = 0.
- Busy drop and mid-reset:
  - Decimal load 1234, then hex load 16'hFFFF at cycle 5 of busy -> ignored; final digits 1,2,3,4.
  - Repeat with reset at cycle 8 -> digits 0,0,0,0, busy = 0; no later commit of 1,2,3,4.

Source files
------------

// File: rtl/display_feed.sv
// Front end of the four-digit 7-segment scanner: divides the system clock down to
// the scan clock and turns a loaded 16-bit value into four hex or BCD digits.
module display_feed #(
    parameter int CLK_FREQ_HZ  = 100000000,
    parameter int SCAN_FREQ_HZ = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        mode,
    output logic        busy,
    output logic        overflow,
    output logic        clk_1K,
    output logic [3:0]  count_1,
    output logic [3:0]  count_2,
    output logic [3:0]  count_3,
    output logic [3:0]  count_4
);
    localparam int DIV = CLK_FREQ_HZ / (2 * SCAN_FREQ_HZ);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [DW-1:0] div_cnt;
    logic [3:0]  iter;
    logic [15:0] shift_reg;
    logic [15:0] bcd;
    logic [15:0] bcd_adj;
    logic        accept;
    logic        dec_start;

    // The divider free-runs; loads and conversions never touch the scan clock phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            clk_1K  <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            clk_1K  <= ~clk_1K;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign accept    = load && (state == IDLE);
    assign dec_start = accept && mode && (value <= 16'd9999);
    assign busy      = (state != IDLE);

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (dec_start) state_next = CONV;
            CONV:    if (iter == 4'd15) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Digits change only on a hex/saturated load or on the DONE commit, never mid-conversion.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_1   <= 4'd0;
            count_2   <= 4'd0;
            count_3   <= 4'd0;
            count_4   <= 4'd0;
            overflow  <= 1'b0;
            iter      <= 4'd0;
            shift_reg <= 16'd0;
            bcd       <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!mode) begin
                            count_1  <= value[15:12];
                            count_2  <= value[11:8];
                            count_3  <= value[7:4];
                            count_4  <= value[3:0];
                            overflow <= 1'b0;
                        end else if (value > 16'd9999) begin
                            count_1  <= 4'd9;
                            count_2  <= 4'd9;
                            count_3  <= 4'd9;
                            count_4  <= 4'd9;
                            overflow <= 1'b1;
                        end else begin
                            shift_reg <= value;
                            bcd       <= 16'd0;
                            iter      <= 4'd0;
                            overflow  <= 1'b0;
                        end
                    end
                end
                CONV: begin
                    {bcd, shift_reg} <= {bcd_adj[14:0], shift_reg, 1'b0};
                    iter             <= iter + 4'd1;
                end
                DONE: begin
                    count_1 <= bcd[15:12];
                    count_2 <= bcd[11:8];
                    count_3 <= bcd[7:4];
                    count_4 <= bcd[3:0];
                end
                default: ;
            endcase
        end
    end
endmodule
